line_scanner: RTL and testbench
===============================

LINE_SCANNER -- requirements
Module: line_scanner

Interface
REQ-001 Parameter WIN_LEN, default 6: run length that counts as a win.
REQ-002 Parameter SPAN, default 5: cells scanned on each side of the centre, giving a window of 2*SPAN+1 = 11 cells.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to scan around (Xin, Yin).
REQ-006 Xin, Yin  in  5 each  centre coordinate, 0..18.
REQ-007 player  in  2  stone colour to match (1 or 2; 0 is treated as no match).
REQ-008 READ  out  1  read strobe to board memory.
REQ-009 XlocV, YlocV, XlocH, YlocH, XlocNE, YlocNE, XlocNW, YlocNW  out  5 each  per-direction read addresses.
REQ-010 verticleDataIN, horizontalDataIN, NEDataIN, NWDataIN  in  2 each  cell contents, valid the cycle after READ.
REQ-011 busy  out  1  scan in progress.
REQ-012 done  out  1  one-cycle pulse when results are valid.
REQ-013 runV, runH, runNE, runNW  out  4 each  longest run of player's colour in the window, per direction.
REQ-014 win  out  1  any run >= WIN_LEN.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL latch Xin, Yin and player, clear the run counters, set offset d=-SPAN and enter ISSUE.
REQ-017 In ISSUE, READ SHALL be 1 and the addresses SHALL be:
- V = (Xc, Yc+d)
- H = (Xc+d, Yc)
- NE = (Xc+d, Yc-d)
- NW = (Xc-d, Yc-d)
REQ-018 The offset d SHALL increment by 1 each ISSUE cycle; after d=+SPAN the FSM SHALL go to DRAIN (one cycle, READ=0), then DONE (one cycle, done=1), then IDLE.
REQ-019 Timing: start high in cycle 0; READ high in cycles 1-11; data consumed in cycles 2-12; done high in cycle 13.
REQ-020 Address arithmetic SHALL be 6-bit signed. A coordinate outside 0..18 SHALL drive address 0, and its returned data SHALL be treated as empty.
REQ-021 Per direction, on each consumed cell:
- cell == player and player != 0 and in-board: cur = cur+1 (saturating at 11), max = max(max, cur+1)
- otherwise: cur = 0
REQ-022 The run and win outputs SHALL update only in DONE and hold until the next DONE; during a scan they keep their previous values.
REQ-023 busy SHALL be 1 in ISSUE, DRAIN and DONE.
REQ-024 start while busy SHALL be ignored, with no effect on the scan in progress.
REQ-025 In DONE, win SHALL be 1 if any of runV, runH, runNE, runNW >= WIN_LEN.
REQ-026 Between READ cycles the module SHALL NOT require board writes to stall; results reflect memory contents at read time.

Reset
REQ-027 On reset=1, regardless of clk, the FSM SHALL return to IDLE.
REQ-028 On reset=1, all outputs SHALL go to 0: READ, every address, busy, done, all run outputs and win.
REQ-029 Reset during a scan SHALL abort it with no done pulse.

Configuration
REQ-030 Macro SCAN_WIN_STICKY_EN.
REQ-031 With SCAN_WIN_STICKY_EN defined, win SHALL be sticky: once set it stays 1 until reset, regardless of later scans.
REQ-032 Without SCAN_WIN_STICKY_EN, win SHALL be recomputed at every DONE.

Verification
REQ-033 Empty board, start at (9,9) with player=1 -> READ for exactly 11 cycles, done in cycle 13, all runs 0, win=0.
REQ-034 Row y=9 holds colour 1 at x=4..9, start at (9,9) with player=1 -> runH=6, win=1, runV=1, runNE=1, runNW=1.
REQ-035 Start at (0,0) -> in-board reads only for d>=0 on H and V, out-of-board cells are treated as empty, and a colour-2 diagonal at (0,0)..(4,4) with player=2 gives runNW=5, win=0.
REQ-036 start re-asserted in cycles 3 and 7 of a scan -> ignored, single done pulse in cycle 13.
REQ-037 reset asserted in cycle 6 -> READ=0 and busy=0 immediately, no done pulse; a new start then completes normally.
REQ-038 With SCAN_WIN_STICKY_EN, a winning scan followed by an empty-board scan -> win stays 1; without the macro -> win returns to 0.

Source files
------------

// File: rtl/line_scanner_if.sv
// line_scanner_if: request, board-read and result signals of line_scanner.
// master = requester / board memory side, slave = the scanner itself.
interface line_scanner_if;
   logic       start;
   logic [4:0] Xin, Yin;
   logic [1:0] player;
   logic       READ;
   logic [4:0] XlocV, YlocV, XlocH, YlocH, XlocNE, YlocNE, XlocNW, YlocNW;
   logic [1:0] verticleDataIN, horizontalDataIN, NEDataIN, NWDataIN;
   logic       busy, done;
   logic [3:0] runV, runH, runNE, runNW;
   logic       win;

   modport master (
      output start, Xin, Yin, player,
      output verticleDataIN, horizontalDataIN, NEDataIN, NWDataIN,
      input  READ, XlocV, YlocV, XlocH, YlocH, XlocNE, YlocNE, XlocNW, YlocNW,
      input  busy, done, runV, runH, runNE, runNW, win
   );

   modport slave (
      input  start, Xin, Yin, player,
      input  verticleDataIN, horizontalDataIN, NEDataIN, NWDataIN,
      output READ, XlocV, YlocV, XlocH, YlocH, XlocNE, YlocNE, XlocNW, YlocNW,
      output busy, done, runV, runH, runNE, runNW, win
   );
endinterface

// File: rtl/line_scanner.sv
// line_scanner: scans 2*SPAN+1 cells through a centre point in four directions
// (vertical, horizontal, NE and NW diagonals) and reports the longest run of
// the requested colour in each, plus a win flag when any run reaches WIN_LEN.
// Optional build macro SCAN_WIN_STICKY_EN: win stays set until reset.
module line_scanner #(
   parameter int WIN_LEN = 6,
   parameter int SPAN    = 5
) (
   input logic         clk,
   input logic         reset,
   line_scanner_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t state, state_nxt;

   logic [4:0]        xc, yc;
   logic [1:0]        pl;
   logic signed [5:0] d;
   logic              rd_q;
   logic [3:0]        inb_q;       // 0=V 1=H 2=NE 3=NW
   logic [3:0][3:0]   cur_q, max_q, cur_nxt, max_nxt, run_q;
   logic              win_q, any_win;
   logic signed [5:0] xs, ys, xp, xm, yp, ym;
   logic [3:0]        inb;
   logic [3:0][1:0]   dat;

   function automatic logic on_board(input logic signed [5:0] v);
      return (v >= 6'sd0) && (v <= 6'sd18);
   endfunction

   function automatic logic [4:0] addr(input logic signed [5:0] v);
      return on_board(v) ? v[4:0] : '0;
   endfunction

   // 6-bit signed coordinates for the current offset
   always_comb begin
      xs  = signed'({1'b0, xc});
      ys  = signed'({1'b0, yc});
      xp  = xs + d;
      xm  = xs - d;
      yp  = ys + d;
      ym  = ys - d;
      inb[0] = on_board(xs) && on_board(yp);
      inb[1] = on_board(xp) && on_board(ys);
      inb[2] = on_board(xp) && on_board(ym);
      inb[3] = on_board(xm) && on_board(ym);
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state, read strobe, addresses and status outputs
   always_comb begin
      state_nxt  = state;
      bus.READ   = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.XlocV  = '0;
      bus.YlocV  = '0;
      bus.XlocH  = '0;
      bus.YlocH  = '0;
      bus.XlocNE = '0;
      bus.YlocNE = '0;
      bus.XlocNW = '0;
      bus.YlocNW = '0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = ISSUE;
         end
         ISSUE: begin
            bus.READ   = 1'b1;
            bus.busy   = 1'b1;
            bus.XlocV  = addr(xs);
            bus.YlocV  = addr(yp);
            bus.XlocH  = addr(xp);
            bus.YlocH  = addr(ys);
            bus.XlocNE = addr(xp);
            bus.YlocNE = addr(ym);
            bus.XlocNW = addr(xm);
            bus.YlocNW = addr(ym);
            if (d == 6'(SPAN)) state_nxt = DRAIN;
         end
         DRAIN: begin
            bus.busy  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            bus.busy  = 1'b1;
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // run counters for the cell returned by the previous read
   always_comb begin
      dat[0]  = bus.verticleDataIN;
      dat[1]  = bus.horizontalDataIN;
      dat[2]  = bus.NEDataIN;
      dat[3]  = bus.NWDataIN;
      cur_nxt = cur_q;
      max_nxt = max_q;
      any_win = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (rd_q) begin
            if (inb_q[i] && (pl != 2'd0) && (dat[i] == pl)) begin
               cur_nxt[i] = (cur_q[i] == 4'd11) ? 4'd11 : cur_q[i] + 4'd1;
               if (cur_nxt[i] > max_q[i]) max_nxt[i] = cur_nxt[i];
            end else begin
               cur_nxt[i] = '0;
            end
         end
         if (int'(max_nxt[i]) >= WIN_LEN) any_win = 1'b1;
      end
   end

   // request latch, offset walk, data pipeline and result registers
   // (results load in DRAIN from max_nxt so the last cell, consumed in
   // DRAIN, is included by the time DONE presents them)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xc    <= '0;
         yc    <= '0;
         pl    <= '0;
         d     <= '0;
         rd_q  <= 1'b0;
         inb_q <= '0;
         cur_q <= '0;
         max_q <= '0;
         run_q <= '0;
         win_q <= 1'b0;
      end else begin
         rd_q  <= (state == ISSUE);
         inb_q <= inb;
         if (state == IDLE && bus.start) begin
            xc    <= bus.Xin;
            yc    <= bus.Yin;
            pl    <= bus.player;
            d     <= 6'(-SPAN);
            cur_q <= '0;
            max_q <= '0;
         end else begin
            if (state == ISSUE) d <= d + 6'sd1;
            cur_q <= cur_nxt;
            max_q <= max_nxt;
         end
         if (state == DRAIN) begin
            run_q <= max_nxt;
`ifdef SCAN_WIN_STICKY_EN
            win_q <= win_q | any_win;
`else
            win_q <= any_win;
`endif
         end
      end
   end

   assign bus.runV  = run_q[0];
   assign bus.runH  = run_q[1];
   assign bus.runNE = run_q[2];
   assign bus.runNW = run_q[3];
   assign bus.win   = win_q;

endmodule

// File: tb/tb_line_scanner.sv
// tb_line_scanner: directed scans against a behavioural board memory; expected
// results are queued at start and checked by a monitor when done pulses.
module tb_line_scanner;

   typedef struct {
      int v, h, ne, nw, w;
   } exp_t;

`ifdef SCAN_WIN_STICKY_EN
   localparam int STICKY = 1;
`else
   localparam int STICKY = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic [1:0] board [32][32];
   exp_t q[$];
   int cyc = 0;
   int start_cyc = 0;
   int total_reads = 0;
   int reads_base = 0;
   int n_checks = 0;
   int n_fail = 0;

   line_scanner_if bus();

   line_scanner #(.WIN_LEN(6), .SPAN(5)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // board memory: data valid the cycle after READ
   always @(posedge clk) begin
      if (bus.READ) begin
         bus.verticleDataIN   <= board[bus.XlocV][bus.YlocV];
         bus.horizontalDataIN <= board[bus.XlocH][bus.YlocH];
         bus.NEDataIN         <= board[bus.XlocNE][bus.YlocNE];
         bus.NWDataIN         <= board[bus.XlocNW][bus.YlocNW];
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.READ) total_reads++;
         if (bus.done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("done_latency", cyc - start_cyc, 13);
               check("read_cycles", total_reads - reads_base, 11);
               check("runV", int'(bus.runV), e.v);
               check("runH", int'(bus.runH), e.h);
               check("runNE", int'(bus.runNE), e.ne);
               check("runNW", int'(bus.runNW), e.nw);
               check("win", int'(bus.win), e.w);
            end
         end
      end
   end

   task automatic clear_board();
      for (int x = 0; x < 32; x++)
         for (int y = 0; y < 32; y++)
            board[x][y] = 2'd0;
   endtask

   task automatic push(input int v, input int h, input int ne, input int nw, input int w);
      exp_t e;
      e.v = v; e.h = h; e.ne = ne; e.nw = nw; e.w = w;
      q.push_back(e);
   endtask

   // leaves the caller at the negedge of cycle 1
   task automatic do_start(input int x, input int y, input int p);
      @(negedge clk);
      bus.Xin    = 5'(x);
      bus.Yin    = 5'(y);
      bus.player = 2'(p);
      bus.start  = 1'b1;
      start_cyc  = cyc;
      reads_base = total_reads;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_until(input int k);
      while (cyc < start_cyc + k) @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.Xin    = '0;
      bus.Yin    = '0;
      bus.player = '0;
      bus.verticleDataIN   = '0;
      bus.horizontalDataIN = '0;
      bus.NEDataIN         = '0;
      bus.NWDataIN         = '0;
      clear_board();
      repeat (3) @(negedge clk);
      check("rst_READ", int'(bus.READ), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_addr", int'(bus.XlocV | bus.YlocV | bus.XlocH | bus.YlocH |
                             bus.XlocNE | bus.YlocNE | bus.XlocNW | bus.YlocNW), 0);
      check("rst_runs", int'(bus.runV | bus.runH | bus.runNE | bus.runNW), 0);
      check("rst_win", int'(bus.win), 0);
      reset = 1'b0;

      // empty board
      push(0, 0, 0, 0, 0);
      do_start(9, 9, 1);
      check("scan_READ", int'(bus.READ), 1);
      check("scan_busy", int'(bus.busy), 1);
      wait_until(15);

      // row y=9, x=4..9 colour 1
      for (int x = 4; x <= 9; x++) board[x][9] = 2'd1;
      push(1, 6, 1, 1, 1);
      do_start(9, 9, 1);
      check("addr_d-5", int'({bus.XlocV, bus.YlocV, bus.XlocH, bus.YlocH,
                              bus.XlocNE, bus.YlocNE, bus.XlocNW, bus.YlocNW}),
            int'({5'd9, 5'd4, 5'd4, 5'd9, 5'd4, 5'd14, 5'd14, 5'd14}));
      wait_until(15);

      // empty board after a win; results hold mid-scan
      clear_board();
      push(0, 0, 0, 0, STICKY);
      do_start(9, 9, 1);
      wait_until(6);
      check("hold_runH", int'(bus.runH), 6);
      check("hold_win", int'(bus.win), 1);
      wait_until(15);

      // colour-2 diagonal (0,0)..(4,4), corner centre
      for (int i = 0; i <= 4; i++) board[i][i] = 2'd2;
      push(1, 1, 1, 5, STICKY);
      do_start(0, 0, 2);
      check("corner_addr", int'({bus.XlocH, bus.YlocV, bus.XlocNW, bus.YlocNW}),
            int'({5'd0, 5'd0, 5'd5, 5'd5}));
      wait_until(15);

      // start re-asserted mid-scan with a different request
      push(1, 1, 1, 5, STICKY);
      do_start(2, 2, 2);
      wait_until(3);
      bus.Xin = 5'd9; bus.Yin = 5'd9; bus.player = 2'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(7);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(15);

      // reset mid-scan, then a fresh winning scan
      clear_board();
      for (int x = 4; x <= 9; x++) board[x][9] = 2'd1;
      do_start(9, 9, 1);
      wait_until(6);
      reset = 1'b1;
      #1;
      check("abort_READ", int'(bus.READ), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_runs", int'(bus.runV | bus.runH | bus.runNE | bus.runNW), 0);
      check("abort_win", int'(bus.win), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      push(1, 6, 1, 1, 1);
      do_start(9, 9, 1);
      wait_until(16);

      check("pending_done", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
